// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Register 0 is the hard-wired zero register when ZERO_REG is set.
    localparam int unsigned ZERO_ADDR = 0;

    typedef logic [ADDR_W_DEF-1:0] rf_addr_t;

    // One read port's result at default width.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  busy;
    } rf_rport_t;

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: zero-register check, write bypass, storage mux.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int NREGS   = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]             rs_addr,
    input  logic                          byp_en,
    input  logic [ADDR_W-1:0]             byp_addr,
    input  logic [DATA_W-1:0]             byp_data,
    input  logic [NREGS-1:0][DATA_W-1:0]  regs,
    input  logic [NREGS-1:0]              busy_vec,
    output logic [DATA_W-1:0]             rs_data,
    output logic                          rs_busy
);

    logic is_zero;
    logic is_byp;

    assign is_zero = (ZERO_REG != 0) && (rs_addr == ADDR_W'(ZERO_ADDR));
    assign is_byp  = (BYPASS != 0) && byp_en && (byp_addr == rs_addr);

    // Priority: zero register, then same-cycle write, then stored state.
    always_comb begin
        rs_data = regs[rs_addr];
        rs_busy = busy_vec[rs_addr];
        if (is_byp) begin
            rs_data = byp_data;
            rs_busy = 1'b0;
        end
        if (is_zero) begin
            rs_data = '0;
            rs_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, NUM_RPORTS read ports, optional
// write-to-read bypass and a per-register busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_RPORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    localparam int NREGS     = 2**ADDR_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rd_wren,
    input  logic [ADDR_W-1:0]            i_rd_addr,
    input  logic [DATA_W-1:0]            i_rd_data,
    input  logic [NUM_RPORTS*ADDR_W-1:0] i_rs_addr,
    output logic [NUM_RPORTS*DATA_W-1:0] o_rs_data,
    output logic [NUM_RPORTS-1:0]        o_rs_busy,
    input  logic                         i_alloc_en,
    input  logic [ADDR_W-1:0]            i_alloc_addr,
    output logic [NREGS-1:0]             o_busy_vec
);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             busy;
    logic                         wr_ok;
    logic                         alloc_ok;
    logic                         byp_en;

    assign wr_ok    = i_rd_wren  && !((ZERO_REG != 0) && (i_rd_addr    == ADDR_W'(ZERO_ADDR)));
    assign alloc_ok = i_alloc_en && !((ZERO_REG != 0) && (i_alloc_addr == ADDR_W'(ZERO_ADDR)));

    // While reset is held every read must show 0 / not busy, so the bypass
    // path is suppressed along with the stored state.
    assign byp_en = i_rd_wren && !i_rst;

    // Storage and scoreboard update; allocate is applied last so it wins
    // over the busy-clear of a write to the same register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[i_rd_addr] <= i_rd_data;
                busy[i_rd_addr] <= 1'b0;
            end
            if (alloc_ok) begin
                busy[i_alloc_addr] <= 1'b1;
            end
        end
    end

    assign o_busy_vec = busy;

    genvar k;
    generate
        for (k = 0; k < NUM_RPORTS; k++) begin : g_rport
            regfile_rport #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_rport (
                .rs_addr  (i_rs_addr[k*ADDR_W +: ADDR_W]),
                .byp_en   (byp_en),
                .byp_addr (i_rd_addr),
                .byp_data (i_rd_data),
                .regs     (regs),
                .busy_vec (busy),
                .rs_data  (o_rs_data[k*DATA_W +: DATA_W]),
                .rs_busy  (o_rs_busy[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: stimulus queues expectations tagged with a cycle number,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wren = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [NP*AW-1:0] rs_addr = '0;
    logic           alloc_en = 1'b0;
    logic [AW-1:0]  alloc_addr = '0;

    logic [NP*DW-1:0] rs_data_b, rs_data_n;
    logic [NP-1:0]    rs_busy_b, rs_busy_n;
    logic [31:0]      vec_b, vec_n;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RPORTS(NP), .BYPASS(1), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wr_addr), .i_rd_data(wr_data),
        .i_rs_addr(rs_addr), .o_rs_data(rs_data_b), .o_rs_busy(rs_busy_b),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_busy_vec(vec_b));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RPORTS(NP), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_rd_wren(wren), .i_rd_addr(wr_addr), .i_rd_data(wr_data),
        .i_rs_addr(rs_addr), .o_rs_data(rs_data_n), .o_rs_busy(rs_busy_n),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_busy_vec(vec_n));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        int          sel;      // 0 = bypassing DUT, 1 = non-bypassing DUT
        int          port;
        logic        vec_only;
        logic [31:0] d;
        logic        b;
        logic [31:0] vec;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] ad;
            logic        ab;
            logic [31:0] av;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: stale expectation (cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (e.vec_only) begin
                av = (e.sel == 0) ? vec_b : vec_n;
                checks++;
                if (av !== e.vec) begin
                    errors++;
                    $display("FAIL %s: busy_vec got %h expected %h", e.name, av, e.vec);
                end
            end else begin
                ad = (e.sel == 0) ? rs_data_b[e.port*DW +: DW] : rs_data_n[e.port*DW +: DW];
                ab = (e.sel == 0) ? rs_busy_b[e.port] : rs_busy_n[e.port];
                checks += 2;
                if (ad !== e.d) begin
                    errors++;
                    $display("FAIL %s: port%0d data got %h expected %h", e.name, e.port, ad, e.d);
                end
                if (ab !== e.b) begin
                    errors++;
                    $display("FAIL %s: port%0d busy got %b expected %b", e.name, e.port, ab, e.b);
                end
            end
        end
    end

    task automatic exp_port(input string name, input int sel, input int port,
                            input logic [31:0] d, input logic b);
        exp_t e;
        e.name = name; e.cyc = cyc; e.sel = sel; e.port = port;
        e.vec_only = 1'b0; e.d = d; e.b = b; e.vec = '0;
        q.push_back(e);
    endtask

    task automatic exp_vec(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.cyc = cyc; e.sel = sel; e.port = 0;
        e.vec_only = 1'b1; e.d = '0; e.b = 1'b0; e.vec = v;
        q.push_back(e);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        wren = 1'b0;
        alloc_en = 1'b0;
    endtask

    task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        set_rs(5'd1, 5'd2);
        exp_port("rst_p0", 0, 0, 32'h0, 1'b0);
        exp_port("rst_p1", 0, 1, 32'h0, 1'b0);
        exp_vec ("rst_vec", 0, 32'h0);

        // Plain write then read next cycle
        tick();
        wren = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        set_rs(5'd3, 5'd4);
        tick();
        set_rs(5'd5, 5'd0);
        exp_port("wr5_p0", 0, 0, 32'h1234_5678, 1'b0);
        exp_port("wr5_zero", 0, 1, 32'h0, 1'b0);
        exp_port("wr5_nb", 1, 0, 32'h1234_5678, 1'b0);

        // Same-cycle bypass vs. no bypass
        tick();
        wren = 1'b1; wr_addr = 5'd10; wr_data = 32'h8765_4321;
        set_rs(5'd10, 5'd10);
        exp_port("byp_p0", 0, 0, 32'h8765_4321, 1'b0);
        exp_port("byp_p1", 0, 1, 32'h8765_4321, 1'b0);
        exp_port("nobyp_p0", 1, 0, 32'h0, 1'b0);
        tick();
        exp_port("nobyp_next", 1, 0, 32'h8765_4321, 1'b0);
        exp_port("byp_next", 0, 1, 32'h8765_4321, 1'b0);

        // Allocate is not forwarded; visible the cycle after
        tick();
        alloc_en = 1'b1; alloc_addr = 5'd15;
        set_rs(5'd15, 5'd15);
        exp_port("alloc_same", 0, 0, 32'h0, 1'b0);
        exp_vec ("alloc_same_vec", 0, 32'h0);
        tick();
        exp_port("alloc_next", 0, 0, 32'h0, 1'b1);
        exp_vec ("alloc_next_vec", 0, 32'h0000_8000);

        // Write releases: bypass clears port busy, vector keeps raw state
        tick();
        wren = 1'b1; wr_addr = 5'd15; wr_data = 32'hAABB_CCDD;
        exp_port("rel_byp", 0, 0, 32'hAABB_CCDD, 1'b0);
        exp_port("rel_nb", 1, 1, 32'h0, 1'b1);
        exp_vec ("rel_vec_raw", 0, 32'h0000_8000);
        tick();
        exp_port("rel_next", 0, 0, 32'hAABB_CCDD, 1'b0);
        exp_vec ("rel_next_vec", 0, 32'h0);

        // Allocate and write same register: allocate wins, data written
        tick();
        wren = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        alloc_en = 1'b1; alloc_addr = 5'd7;
        set_rs(5'd7, 5'd7);
        exp_port("aw7_same", 0, 0, 32'h55, 1'b0);
        tick();
        exp_port("aw7_next", 0, 0, 32'h55, 1'b1);
        exp_vec ("aw7_vec", 0, 32'h0000_0080);

        // Register 0 ignores write and allocate
        tick();
        wren = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        set_rs(5'd0, 5'd0);
        exp_port("r0_same", 0, 0, 32'h0, 1'b0);
        exp_port("r0_same_nb", 1, 1, 32'h0, 1'b0);
        tick();
        exp_port("r0_next", 0, 1, 32'h0, 1'b0);
        exp_vec ("r0_vec", 0, 32'h0000_0080);

        // Fill 1..31 with index
        for (int i = 1; i < 32; i++) begin
            tick();
            wren = 1'b1; wr_addr = AW'(i); wr_data = 32'(i);
        end
        tick();
        set_rs(5'd20, 5'd31);
        alloc_en = 1'b1; alloc_addr = 5'd3;
        exp_port("fill_20", 0, 0, 32'd20, 1'b0);
        exp_port("fill_31", 0, 1, 32'd31, 1'b0);
        tick();
        set_rs(5'd7, 5'd3);
        exp_port("fill_7", 0, 0, 32'd7, 1'b0);
        exp_port("fill_3busy", 0, 1, 32'd3, 1'b1);
        exp_vec ("fill_vec", 0, 32'h0000_0008);

        // Asynchronous reset between edges
        tick();
        set_rs(5'd20, 5'd31);
        #1;
        rst = 1'b1;
        #1;
        exp_port("arst_20", 0, 0, 32'h0, 1'b0);
        exp_port("arst_31", 0, 1, 32'h0, 1'b0);
        exp_vec ("arst_vec", 0, 32'h0);
        exp_vec ("arst_vec_nb", 1, 32'h0);

        // Writes during reset have no effect and are not forwarded
        tick();
        wren = 1'b1; wr_addr = 5'd20; wr_data = 32'hBAD;
        exp_port("inrst_byp", 0, 0, 32'h0, 1'b0);
        tick();
        exp_port("inrst_20", 0, 0, 32'h0, 1'b0);

        // First write after deassertion
        rst = 1'b0;
        wren = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFE;
        set_rs(5'd21, 5'd31);
        exp_port("post_21", 0, 0, 32'h0, 1'b0);
        tick();
        set_rs(5'd20, 5'd31);
        exp_port("post_20", 0, 0, 32'hCAFE, 1'b0);
        exp_port("post_31", 0, 1, 32'h0, 1'b0);
        exp_port("post_20_nb", 1, 0, 32'hCAFE, 1'b0);

        // Drain with a bounded wait
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never checked", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
